heichips25_input_conditioner: RTL
=================================

Name: heichips25_input_conditioner

Overview:
- Input front-end that sits directly upstream of the tiny wrapper; its conditioned outputs drive the wrapper's `ui_in` bus, which is shared by both projects.
- Per bit: an N-stage synchronizer, then a consecutive-sample debounce filter, then registered rise/fall edge pulses.
- Gives both projects metastability-safe, bounce-free inputs and single-cycle edge strobes, so no project has to re-implement this.

Parameters:
- WIDTH, 8: number of conditioned input bits.
- SYNC_STAGES, 2: synchronizer flop depth; legal values are ≥2.
- DEBOUNCE_CYCLES, 16: consecutive differing synchronized samples required before the clean output changes; legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  filter enable; high = filtering active.
- pin_in  input  WIDTH  raw asynchronous pad inputs.
- clean_out  output  WIDTH  debounced level; feeds wrapper `ui_in`.
- rise_out  output  WIDTH  one-cycle pulse when clean_out bit goes 0→1.
- fall_out  output  WIDTH  one-cycle pulse when clean_out bit goes 1→0.
- any_edge  output  1  OR-reduction of rise_out | fall_out, registered in the same cycle.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- glitch_cnt  output  8  count of aborted debounce attempts (see Optional Feature).

Behaviour:
- Clock and reset:
  - Single clock: clk. Reset is asynchronous and active-low: rst_n.
  - While rst_n=0, all flops are cleared: synchronizer chain, debounce counters, clean_out, rise_out, fall_out, any_edge and glitch_cnt all read 0.
  - Deassertion is synchronous to clk; the first active edge follows.
- Synchronizer:
  - Per-bit chain of SYNC_STAGES flops; always clocks, independent of ena.
  - Synchronized bit s[i] = last stage.
- Debounce counter:
  - Per-bit counter cnt[i], width clog2(DEBOUNCE_CYCLES) (min 1), evaluated each edge with ena=1.
  - s[i]==clean[i] → cnt[i]<=0.
  - s[i]!=clean[i] and cnt[i]<DEBOUNCE_CYCLES-1 → cnt[i]<=cnt[i]+1.
  - s[i]!=clean[i] and cnt[i]==DEBOUNCE_CYCLES-1 → clean[i]<=s[i], cnt[i]<=0, and rise[i] or fall[i] asserted for exactly this one cycle.
  - No wrap-around: cnt never exceeds DEBOUNCE_CYCLES-1.
- Latency:
  - pin_in change sampled at edge k → clean_out changes at edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES.
  - rise_out/fall_out assert coincident with the clean_out change.
  - any_edge asserts in the same cycle.
- Pulse bursts: any difference-free sample restarts the count from 0, so a burst shorter than DEBOUNCE_CYCLES produces no output change.
- DEBOUNCE_CYCLES=1: clean_out follows s with exactly one cycle delay; no filtering.
- Per-bit independence: bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses on those bits.
- ena=0:
  - All cnt cleared; clean_out holds its value.
  - rise_out, fall_out and any_edge forced 0 on the next edge.
  - The synchronizer keeps running.
- ena 0→1: debounce restarts from cnt=0, so a full DEBOUNCE_CYCLES of difference is needed before any change.
- Reset mid-debounce: counters and outputs clear immediately; no pulse is emitted for the interrupted transition.
- Outputs: all outputs are registered; no combinational path from pin_in to any output.

Optional Feature:
- Macro: INPUT_COND_GLITCH_CNT_EN.
- Defined:
  - Event counted: any bit with cnt[i]>0 whose s[i] returns to clean[i] (aborted attempt).
  - Each such edge increments glitch_cnt by the number of aborting bits, saturating at 255.
  - glitch_clr=1 sets glitch_cnt to 0 on the next edge; clear wins over a same-cycle increment.
  - ena=0 aborts are not counted.
- Undefined:
  - glitch_cnt tied to 0; glitch_clr ignored.
  - No counter logic synthesized; port list unchanged.

Test Plan:
- Reset with pin_in=8'hFF held → all outputs 0 during reset. After rst_n rises (DEBOUNCE_CYCLES=4, SYNC_STAGES=2), clean_out=8'hFF at edge 5 after the first sample. rise_out=8'hFF and any_edge=1 for exactly that one cycle.
- Clean step: pin_in[3] 0→1, sampled at edge k → clean_out[3]=1 at edge k+5; rise_out=8'h08 for one cycle. Returning it to 0 later gives fall_out=8'h08 five edges after sampling.
- Bounce: pin_in[0] pulsed high for 3 cycles, low 1, high 3, then low → clean_out, rise_out and fall_out stay 0. With INPUT_COND_GLITCH_CNT_EN, glitch_cnt=2.
- Simultaneous: pin_in 8'h00→8'hA5 in one cycle → clean_out=8'hA5 and rise_out=8'hA5 on the same edge. Then 8'hA5→8'h5A → rise_out=8'h5A and fall_out=8'hA5 together.
- ena gating: ena=0 while pin_in[7] toggles and is held 10 cycles → clean_out[7] unchanged, no pulses. Set ena=1 → clean_out[7] updates exactly 4 edges later.
- Reset mid-operation: assert rst_n=0 with cnt[2]=3 → clean_out, counters and pulses 0 immediately, no pulse after release. glitch_clr coincident with a glitch → glitch_cnt=0.

Source files
------------

// File: rtl/heichips25_input_conditioner_if.sv
// Signal bundle between the pad-side driver and the input conditioner.
// The master drives raw pads and control; the slave returns conditioned levels and strobes.
interface heichips25_input_conditioner_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic [WIDTH-1:0] pin_in;
    logic             glitch_clr;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] rise_out;
    logic [WIDTH-1:0] fall_out;
    logic             any_edge;
    logic [7:0]       glitch_cnt;

    modport master (
        output ena,
        output pin_in,
        output glitch_clr,
        input  clean_out,
        input  rise_out,
        input  fall_out,
        input  any_edge,
        input  glitch_cnt
    );

    modport slave (
        input  ena,
        input  pin_in,
        input  glitch_clr,
        output clean_out,
        output rise_out,
        output fall_out,
        output any_edge,
        output glitch_cnt
    );
endinterface

// File: rtl/heichips25_input_conditioner.sv
// Per-bit synchronizer, consecutive-sample debounce and registered edge strobes feeding ui_in.
// Define INPUT_COND_GLITCH_CNT_EN to build the saturating aborted-debounce counter on glitch_cnt.
module heichips25_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic                          clk,
    input logic                          rst_n,
    heichips25_input_conditioner_if.slave bus
);
    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_s;

    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]            r_clean;
    logic [WIDTH-1:0]            w_clean_nxt;
    logic [WIDTH-1:0]            r_rise;
    logic [WIDTH-1:0]            w_rise_nxt;
    logic [WIDTH-1:0]            r_fall;
    logic [WIDTH-1:0]            w_fall_nxt;
    logic                        r_any;

    // Synchronizer runs regardless of ena; stage 0 takes the raw pad value.
    // NOTE: sequential state uses <= so every flop samples pre-edge values, keeping the chain a true shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pin_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_clean;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!bus.ena || (w_s[i] == r_clean[i])) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_cnt_nxt[i]   = '0;
                w_clean_nxt[i] = w_s[i];
                w_rise_nxt[i]  = w_s[i];
                w_fall_nxt[i]  = ~w_s[i];
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Strobes are registered alongside the level so they coincide with the clean_out change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_clean <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_any   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_any   <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign bus.clean_out = r_clean;
    assign bus.rise_out  = r_rise;
    assign bus.fall_out  = r_fall;
    assign bus.any_edge  = r_any;

`ifdef INPUT_COND_GLITCH_CNT_EN
    logic [WIDTH-1:0] w_abort;
    logic [15:0]      w_abort_num;
    logic [15:0]      w_glitch_sum;
    logic [7:0]       w_glitch_nxt;
    logic [7:0]       r_glitch_cnt;

    // An abort is a bit that had started counting and saw its input fall back to the clean level.
    always_comb begin
        w_abort     = '0;
        w_abort_num = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_abort[i]  = bus.ena && (w_s[i] == r_clean[i]) && (r_cnt[i] != '0);
            w_abort_num = w_abort_num + 16'(w_abort[i]);
        end
        w_glitch_sum = 16'(r_glitch_cnt) + w_abort_num;
        w_glitch_nxt = (w_glitch_sum > 16'd255) ? 8'hFF : w_glitch_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= '0;
        end else if (bus.glitch_clr) begin
            r_glitch_cnt <= '0;
        end else begin
            r_glitch_cnt <= w_glitch_nxt;
        end
    end

    assign bus.glitch_cnt = r_glitch_cnt;
`else
    logic w_unused_glitch_clr;

    assign w_unused_glitch_clr = bus.glitch_clr;
    assign bus.glitch_cnt      = '0;
`endif

endmodule
